// File: rtl/alu_pkg.sv
// alu_pkg: op-code and FSM state encodings shared by the slice-serial ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_SLT  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_NAND = 3'd5;
    localparam logic [2:0] OP_NOR  = 3'd6;
    localparam logic [2:0] OP_OR   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_slice.sv
// alu_slice: combinational SLICE-bit ALU chunk; b_s arrives already inverted for SUB/SLT.
module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    input  logic             cin,
    input  logic [2:0]       command,
    output logic [SLICE-1:0] y_s,
    output logic             cout,
    output logic             c_into_msb
);

    logic [SLICE:0]   c;
    logic [SLICE-1:0] sum;

    always_comb begin
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            sum[i]   = a_s[i] ^ b_s[i] ^ c[i];
            c[i+1]   = (a_s[i] & b_s[i]) | ((a_s[i] ^ b_s[i]) & c[i]);
        end
        cout       = c[SLICE];
        c_into_msb = c[SLICE-1];
        case (command)
            OP_XOR:  y_s = a_s ^ b_s;
            OP_AND:  y_s = a_s & b_s;
            OP_NAND: y_s = ~(a_s & b_s);
            OP_NOR:  y_s = ~(a_s | b_s);
            OP_OR:   y_s = a_s | b_s;
            default: y_s = sum;
        endcase
    end

endmodule

// File: rtl/alu_seq_sliced.sv
// alu_seq_sliced: slice-serial ALU, one SLICE-bit chunk per clock, LS slice first,
// with valid/ready handshakes on operand and result sides.
module alu_seq_sliced
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       command,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = NSLICE > 1 ? $clog2(NSLICE) : 1;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [2:0]       cmd_q, cmd_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
    logic             carryout_q, carryout_d, overflow_q, overflow_d, zero_q, zero_d;

    logic             sub, last, accept, arith, ovf, cout, cmsb;
    logic [SLICE-1:0] a_s, b_s, y_s;
    logic [WIDTH-1:0] fin;

    // SUB/SLT feed ~b with carry-in 1, so the slice only ever adds
    assign sub = (cmd_q == OP_SUB) || (cmd_q == OP_SLT);
    assign a_s = a_q[int'(idx_q)*SLICE +: SLICE];
    assign b_s = b_q[int'(idx_q)*SLICE +: SLICE] ^ {SLICE{sub}};

    alu_slice #(.SLICE(SLICE)) u_slice (
        .a_s        (a_s),
        .b_s        (b_s),
        .cin        (carry_q),
        .command    (cmd_q),
        .y_s        (y_s),
        .cout       (cout),
        .c_into_msb (cmsb)
    );

    always_comb begin
        in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        out_valid  = state_q == DONE;
        accept     = in_valid && in_ready;
        last       = idx_q == IW'(NSLICE - 1);
        arith      = (cmd_q == OP_ADD) || (cmd_q == OP_SUB);
        ovf        = cmsb ^ cout;
        fin        = acc_q;
        fin[int'(idx_q)*SLICE +: SLICE] = y_s;
        state_d    = state_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        cmd_d      = cmd_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        result_d   = result_q;
        carryout_d = carryout_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        if (state_q == RUN) begin
            acc_d   = fin;
            carry_d = cout;
            idx_d   = last ? '0 : idx_q + IW'(1);
            if (last) begin
                state_d    = DONE;
                result_d   = (cmd_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, fin[WIDTH-1] ^ ovf} : fin;
                carryout_d = arith && cout;
                overflow_d = arith && ovf;
                zero_d     = result_d == '0;
            end
        end
        if ((state_q == DONE) && out_ready)
            state_d = IDLE;
        if (accept) begin
            state_d = RUN;
            a_d     = a;
            b_d     = b;
            cmd_d   = command;
            idx_d   = '0;
            carry_d = (command == OP_SUB) || (command == OP_SLT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            cmd_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            cmd_q      <= cmd_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            carryout_q <= carryout_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign result   = result_q;
    assign carryout = carryout_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_alu_seq_sliced.sv
// tb_alu_seq_sliced: random + directed checks of three ALU instances (SLICE 8, 1, 32)
// against an arithmetic reference model.
module tb_alu_seq_sliced;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   command;
    logic [W-1:0] a, b;
    logic         iv [3];
    logic         ir [3];
    logic         ov [3];
    logic         ordy [3];
    logic         co [3];
    logic         of [3];
    logic         z [3];
    logic [W-1:0] res [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq_sliced #(.WIDTH(W), .SLICE(8)) u_s8 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .command(command),
        .a(a), .b(b), .out_valid(ov[0]), .out_ready(ordy[0]), .result(res[0]),
        .carryout(co[0]), .overflow(of[0]), .zero(z[0]));

    alu_seq_sliced #(.WIDTH(W), .SLICE(1)) u_s1 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .command(command),
        .a(a), .b(b), .out_valid(ov[1]), .out_ready(ordy[1]), .result(res[1]),
        .carryout(co[1]), .overflow(of[1]), .zero(z[1]));

    alu_seq_sliced #(.WIDTH(W), .SLICE(W)) u_s32 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .command(command),
        .a(a), .b(b), .out_valid(ov[2]), .out_ready(ordy[2]), .result(res[2]),
        .carryout(co[2]), .overflow(of[2]), .zero(z[2]));

    function automatic int lat_of(input int k);
        return k == 0 ? 4 : (k == 1 ? 32 : 1);
    endfunction

    // Returns {carryout, overflow, zero, result} from plain integer arithmetic
    function automatic logic [W+2:0] ref_op(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         cf, vf;
        cf = 1'b0;
        vf = 1'b0;
        r  = '0;
        case (c)
            3'd0: begin
                s  = {1'b0, x} + {1'b0, y};
                r  = s[W-1:0];
                cf = s[W];
                vf = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'd1: begin
                r  = x - y;
                cf = x >= y;
                vf = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'd2: r = x ^ y;
            3'd3: r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            3'd4: r = x & y;
            3'd5: r = ~(x & y);
            3'd6: r = ~(x | y);
            default: r = x | y;
        endcase
        return {cf, vf, r == '0, r};
    endfunction

    task automatic do_op(input int k, input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W+2:0] got, output int lat);
        @(negedge clk);
        command = c;
        a       = x;
        b       = y;
        iv[k]   = 1'b1;
        ordy[k] = 1'b0;
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
        lat   = 0;
        while (!ov[k] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got     = {co[k], of[k], z[k], res[k]};
        ordy[k] = 1'b1;
        @(posedge clk);
        #1;
        ordy[k] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        command = '0;
        a = '0;
        b = '0;
        for (int k = 0; k < 3; k++) begin
            iv[k]   = 1'b0;
            ordy[k] = 1'b0;
        end
        #12;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({ov[k], ir[k], co[k], of[k], z[k], res[k]} !== {1'b0, 1'b1, 3'b000, W'(0)}) begin
                n_fail++;
                $display("FAIL reset[%0d]: got ov=%b ir=%b co=%b of=%b z=%b res=%h, want ov=0 ir=1 flags=000 res=0",
                         k, ov[k], ir[k], co[k], of[k], z[k], res[k]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic directed_vec(input int i, output logic [2:0] c, output logic [W-1:0] x, output logic [W-1:0] y);
        case (i)
            0:  begin c = 3'd0; x = 32'h7FFFFFFF; y = 32'h00000001; end
            1:  begin c = 3'd1; x = 32'h00000005; y = 32'h00000005; end
            2:  begin c = 3'd0; x = 32'hFFFFFFFF; y = 32'h00000001; end
            3:  begin c = 3'd3; x = 32'h80000000; y = 32'h7FFFFFFF; end
            4:  begin c = 3'd3; x = 32'h7FFFFFFF; y = 32'h80000000; end
            5:  begin c = 3'd3; x = 32'hFFFFFFFF; y = 32'h00000001; end
            6:  begin c = 3'd3; x = 32'h00000007; y = 32'h00000007; end
            7:  begin c = 3'd2; x = 32'hF0F0A5A5; y = 32'hFF00FF00; end
            8:  begin c = 3'd4; x = 32'hF0F0A5A5; y = 32'hFF00FF00; end
            9:  begin c = 3'd5; x = 32'hF0F0A5A5; y = 32'hFF00FF00; end
            10: begin c = 3'd6; x = 32'hF0F0A5A5; y = 32'hFF00FF00; end
            default: begin c = 3'd7; x = 32'hF0F0A5A5; y = 32'hFF00FF00; end
        endcase
    endtask

    task automatic test_ops(input int k, input int n_rand);
        logic [2:0]   c;
        logic [W-1:0] x, y;
        logic [W+2:0] got, exp;
        int           lat;
        for (int i = 0; i < 12 + n_rand; i++) begin
            if (i < 12) directed_vec(i, c, x, y);
            else begin
                c = 3'($urandom_range(0, 7));
                x = $urandom;
                y = ($urandom_range(0, 3) == 0) ? x : $urandom;
            end
            exp = ref_op(c, x, y);
            do_op(k, c, x, y, got, lat);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL op[%0d] cmd=%0d a=%h b=%h: got co/of/z=%b res=%h, want co/of/z=%b res=%h",
                         k, c, x, y, got[W+2:W], got[W-1:0], exp[W+2:W], exp[W-1:0]);
            end
            n_checks++;
            if (lat !== lat_of(k)) begin
                n_fail++;
                $display("FAIL latency[%0d] cmd=%0d: got %0d cycles, want %0d", k, c, lat, lat_of(k));
            end
        end
    endtask

    task automatic test_handshake();
        logic [W-1:0] x1, y1, r0;
        logic [W+2:0] exp;
        int           lat;
        @(negedge clk);
        command = 3'd0;
        a       = $urandom;
        b       = $urandom;
        iv[0]   = 1'b1;
        ordy[0] = 1'b0;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        lat   = 0;
        while (!ov[0] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r0 = res[0];
        // Offer a junk op while stalled; it must not be taken
        iv[0]   = 1'b1;
        command = 3'd7;
        a       = $urandom;
        b       = $urandom;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({ov[0], ir[0], res[0]} !== {1'b1, 1'b0, r0}) begin
                n_fail++;
                $display("FAIL hold cycle %0d: got ov=%b ir=%b res=%h, want ov=1 ir=0 res=%h",
                         i, ov[0], ir[0], res[0], r0);
            end
        end
        @(negedge clk);
        x1      = $urandom;
        y1      = $urandom;
        command = 3'd1;
        a       = x1;
        b       = y1;
        ordy[0] = 1'b1;
        #1;
        n_checks++;
        if (ir[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL in_ready_follows_out_ready: got %b, want 1", ir[0]);
        end
        @(posedge clk);
        #1;
        iv[0]   = 1'b0;
        ordy[0] = 1'b0;
        n_checks++;
        if (ov[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back accept: out_valid got %b, want 0", ov[0]);
        end
        lat = 0;
        while (!ov[0] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        exp = ref_op(3'd1, x1, y1);
        n_checks++;
        if ({co[0], of[0], z[0], res[0]} !== exp || lat != 4) begin
            n_fail++;
            $display("FAIL back_to_back result: got res=%h flags=%b lat=%0d, want res=%h flags=%b lat=4",
                     res[0], {co[0], of[0], z[0]}, lat, exp[W-1:0], exp[W+2:W]);
        end
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [W+2:0] got, exp;
        int           lat;
        do_op(0, 3'd0, 32'h12345678, 32'h11111111, got, lat);
        @(negedge clk);
        command = 3'd0;
        a       = 32'hDEADBEEF;
        b       = 32'h01010101;
        iv[0]   = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({ov[0], ir[0], co[0], of[0], z[0], res[0]} !== {1'b0, 1'b1, 3'b000, W'(0)}) begin
            n_fail++;
            $display("FAIL reset_mid_run: got ov=%b ir=%b flags=%b res=%h, want ov=0 ir=1 flags=000 res=0",
                     ov[0], ir[0], {co[0], of[0], z[0]}, res[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        exp = ref_op(3'd3, 32'h80000000, 32'h00000001);
        do_op(0, 3'd3, 32'h80000000, 32'h00000001, got, lat);
        n_checks++;
        if (got !== exp || lat != 4) begin
            n_fail++;
            $display("FAIL after_reset op: got res=%h flags=%b lat=%0d, want res=%h flags=%b lat=4",
                     got[W-1:0], got[W+2:W], lat, exp[W-1:0], exp[W+2:W]);
        end
    endtask

    initial begin
        test_reset();
        test_ops(0, 40);
        test_handshake();
        test_reset_mid_run();
        test_ops(1, 10);
        test_ops(2, 20);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
